// File: rtl/lz77_pkg.sv
// Shared definitions for the LZ77 set-bit scanner: scan-order encodings,
// FSM state encodings and the width helper used to size positions.
package lz77_pkg;

  localparam int DIR_LSB = 0;
  localparam int DIR_MSB = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int LOG2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lz77_find_first.sv
// Two-level find-first encoder: OR-reduce each group, pick the first
// non-empty group in scan order, then the first set bit inside it.
module lz77_find_first
  import lz77_pkg::*;
#(
  parameter int DAT_WD = 64,
  parameter int GRP_WD = 8,
  parameter int DIR    = DIR_LSB,
  localparam int POS_WD = LOG2(DAT_WD) + 1
) (
  input  logic [DAT_WD-1:0] dat_i,
  output logic              any_o,
  output logic [POS_WD-1:0] idx_o
);

  localparam int NGRP = DAT_WD / GRP_WD;

  logic [NGRP-1:0]   w_grp_any;
  logic [GRP_WD-1:0] w_grp_bits;
  int                w_sel_g;
  int                w_sel_b;

  // Group occupancy flags.
  always_comb begin
    w_grp_any = '0;
    for (int g = 0; g < NGRP; g++) begin
      w_grp_any[g] = |dat_i[g*GRP_WD +: GRP_WD];
    end
  end

  // Group pick, then bit pick; the loop visiting order makes the last hit
  // the winner, so LSB-first walks downwards and MSB-first walks upwards.
  always_comb begin
    w_sel_g = 0;
    if (DIR == DIR_LSB) begin
      for (int g = NGRP - 1; g >= 0; g--) if (w_grp_any[g]) w_sel_g = g;
    end else begin
      for (int g = 0; g < NGRP; g++) if (w_grp_any[g]) w_sel_g = g;
    end
    w_grp_bits = GRP_WD'(dat_i >> (w_sel_g * GRP_WD));
    w_sel_b = 0;
    if (DIR == DIR_LSB) begin
      for (int b = GRP_WD - 1; b >= 0; b--) if (w_grp_bits[b]) w_sel_b = b;
    end else begin
      for (int b = 0; b < GRP_WD; b++) if (w_grp_bits[b]) w_sel_b = b;
    end
    any_o = |w_grp_any;
    idx_o = POS_WD'(w_sel_g * GRP_WD + w_sel_b);
  end

endmodule

// File: rtl/lz77_scan_ones.sv
// Iterative set-bit scanner: accepts a match-flag vector and streams out
// the 1-based position of each set bit, one per cycle, in DIR order.
module lz77_scan_ones
  import lz77_pkg::*;
#(
  parameter int DAT_WD = 64,
  parameter int GRP_WD = 8,
  parameter int DIR    = DIR_LSB,
  localparam int POS_WD = LOG2(DAT_WD) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              val_i,
  input  logic [DAT_WD-1:0] dat_i,
  input  logic              rdy_i,
  output logic              rdy_o,
  output logic              val_o,
  output logic [POS_WD-1:0] pos_o,
  output logic [POS_WD-1:0] idx_o,
  output logic              last_o,
  output logic              zero_o
);

  logic [0:0]        r_state;
  logic [DAT_WD-1:0] r_mask;
  logic [POS_WD-1:0] r_cnt;
  logic              r_val;
  logic [POS_WD-1:0] r_pos;
  logic [POS_WD-1:0] r_idx;
  logic              r_last;
  logic              r_zero;

  logic              w_any;
  logic [POS_WD-1:0] w_first;
  logic [DAT_WD-1:0] w_clr_bit;
  logic [DAT_WD-1:0] w_mask_nxt;
  logic              w_adv;

  lz77_find_first #(
    .DAT_WD (DAT_WD),
    .GRP_WD (GRP_WD),
    .DIR    (DIR)
  ) u_find (
    .dat_i (r_mask),
    .any_o (w_any),
    .idx_o (w_first)
  );

  // Output register is free when empty or being consumed this cycle.
  assign w_adv      = !r_val || rdy_i;
  assign w_clr_bit  = {{(DAT_WD-1){1'b0}}, 1'b1} << w_first;
  assign w_mask_nxt = r_mask & ~w_clr_bit;

  assign rdy_o  = (r_state == ST_IDLE);
  assign val_o  = r_val;
  assign pos_o  = r_pos;
  assign idx_o  = r_idx;
  assign last_o = r_last;
  assign zero_o = r_zero;

  // Scan FSM, working mask and registered output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_val   <= 1'b0;
      r_pos   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (clr_i) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_val   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The last output of the previous vector may still be waiting.
          if (r_val && rdy_i) r_val <= 1'b0;
          if (val_i) begin
            r_mask  <= dat_i;
            r_cnt   <= '0;
            r_state <= ST_SCAN;
          end
        end
        default: begin
          if (w_adv) begin
            r_val <= 1'b1;
            if (w_any) begin
              r_pos  <= w_first + POS_WD'(1);
              r_idx  <= r_cnt;
              r_zero <= 1'b0;
              r_mask <= w_mask_nxt;
              r_cnt  <= r_cnt + POS_WD'(1);
              r_last <= (w_mask_nxt == '0);
              if (w_mask_nxt == '0) r_state <= ST_IDLE;
            end else begin
              // Only reachable for an all-zero vector: one marker output.
              r_pos   <= POS_WD'(DAT_WD + 1);
              r_idx   <= '0;
              r_zero  <= 1'b1;
              r_last  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_scan_ones.sv
// Bench for lz77_scan_ones: an LSB-first and an MSB-first instance share
// one stimulus stream and are compared against a set-bit list model.
module tb_lz77_scan_ones;

  localparam int DW = 64;
  localparam int PW = 7;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          clr_i = 1'b0;
  logic          val_i = 1'b0;
  logic          rdy_i = 1'b0;
  logic [DW-1:0] dat_i = '0;

  logic          rdy0, val0, last0, zero0;
  logic [PW-1:0] pos0, idx0;
  logic          rdy1, val1, last1, zero1;
  logic [PW-1:0] pos1, idx1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [PW-1:0] p0;
    logic [PW-1:0] p1;
    logic [PW-1:0] idx;
    logic          last;
    logic          zero;
  } exp_t;

  exp_t          eq[$];
  logic [DW-1:0] inq[$];

  always #5 clk = ~clk;

  lz77_scan_ones #(.DAT_WD(DW), .GRP_WD(8), .DIR(0)) u_lsb (
    .clk(clk), .rstn(rstn), .clr_i(clr_i), .val_i(val_i), .dat_i(dat_i),
    .rdy_i(rdy_i), .rdy_o(rdy0), .val_o(val0), .pos_o(pos0), .idx_o(idx0),
    .last_o(last0), .zero_o(zero0)
  );

  lz77_scan_ones #(.DAT_WD(DW), .GRP_WD(8), .DIR(1)) u_msb (
    .clk(clk), .rstn(rstn), .clr_i(clr_i), .val_i(val_i), .dat_i(dat_i),
    .rdy_i(rdy_i), .rdy_o(rdy1), .val_o(val1), .pos_o(pos1), .idx_o(idx1),
    .last_o(last1), .zero_o(zero1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of one vector: ascending list of set-bit positions,
  // reversed for the MSB-first instance; an empty vector gives one marker.
  task automatic model_push(input logic [DW-1:0] v);
    int   asc[$];
    exp_t e;
    for (int i = 0; i < DW; i++) if (v[i]) asc.push_back(i + 1);
    if (asc.size() == 0) begin
      e.p0 = PW'(DW + 1); e.p1 = PW'(DW + 1); e.idx = '0;
      e.last = 1'b1; e.zero = 1'b1;
      eq.push_back(e);
    end else begin
      for (int k = 0; k < asc.size(); k++) begin
        e.p0   = PW'(asc[k]);
        e.p1   = PW'(asc[asc.size() - 1 - k]);
        e.idx  = PW'(k);
        e.last = (k == asc.size() - 1);
        e.zero = 1'b0;
        eq.push_back(e);
      end
    end
  endtask

  // Streams inq into the DUTs and checks every consumed output, hold
  // stability and ready behaviour. mode: 0 rdy=1, 1 rdy=1,0,0,..., 2 random.
  task automatic run(input int mode, input int budget);
    int            cyc;
    bit            held;
    logic [PW-1:0] hp0, hp1, hi;
    logic          hl, hz;
    exp_t          e;
    cyc = 0; held = 1'b0;
    hp0 = '0; hp1 = '0; hi = '0; hl = 1'b0; hz = 1'b0;
    while ((inq.size() != 0 || eq.size() != 0) && cyc < budget) begin
      case (mode)
        0:       rdy_i = 1'b1;
        1:       rdy_i = (cyc % 3 == 0);
        default: rdy_i = 1'($urandom_range(0, 1));
      endcase
      chk("val_lockstep", 64'(val1), 64'(val0));
      chk("rdy_lockstep", 64'(rdy1), 64'(rdy0));
      if (held) begin
        chk("hold_val",  64'(val0),  64'd1);
        chk("hold_pos0", 64'(pos0),  64'(hp0));
        chk("hold_pos1", 64'(pos1),  64'(hp1));
        chk("hold_idx",  64'(idx0),  64'(hi));
        chk("hold_last", 64'(last0), 64'(hl));
        chk("hold_zero", 64'(zero0), 64'(hz));
      end
      if (val0) begin
        if (!last0)     chk("rdy_busy",    64'(rdy0), 64'd0);
        else if (!held) chk("rdy_at_last", 64'(rdy0), 64'd1);
      end
      if (val0 && rdy_i) begin
        if (eq.size() == 0) begin
          chk("extra_output", 64'(val0), 64'd0);
        end else begin
          e = eq.pop_front();
          chk("pos_lsb",  64'(pos0),  64'(e.p0));
          chk("pos_msb",  64'(pos1),  64'(e.p1));
          chk("idx_lsb",  64'(idx0),  64'(e.idx));
          chk("idx_msb",  64'(idx1),  64'(e.idx));
          chk("last_lsb", 64'(last0), 64'(e.last));
          chk("last_msb", 64'(last1), 64'(e.last));
          chk("zero_lsb", 64'(zero0), 64'(e.zero));
          chk("zero_msb", 64'(zero1), 64'(e.zero));
        end
      end
      held = val0 && !rdy_i;
      if (held) begin
        hp0 = pos0; hp1 = pos1; hi = idx0; hl = last0; hz = zero0;
      end
      if (inq.size() != 0 && rdy0) begin
        val_i = 1'b1;
        dat_i = inq[0];
        model_push(inq.pop_front());
      end else begin
        val_i = 1'b0;
      end
      tick();
      cyc++;
    end
    val_i = 1'b0;
    rdy_i = 1'b1;
    chk("run_drained", 64'(eq.size() + inq.size()), 64'd0);
    eq.delete();
    inq.delete();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rdy"},  64'(rdy0),  64'd1);
    chk({tag, "_val"},  64'(val0),  64'd0);
    chk({tag, "_pos"},  64'(pos0),  64'd0);
    chk({tag, "_idx"},  64'(idx0),  64'd0);
    chk({tag, "_last"}, 64'(last0), 64'd0);
    chk({tag, "_zero"}, 64'(zero0), 64'd0);
    chk({tag, "_val1"}, 64'(val1),  64'd0);
    chk({tag, "_pos1"}, 64'(pos1),  64'd0);
  endtask

  initial begin
    logic [DW-1:0] v;

    // Reset
    #1 rstn = 1'b0;
    #3 chk_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Single bit: latency and single-cycle valid
    rdy_i = 1'b1; val_i = 1'b1; dat_i = 64'h1;
    tick();
    val_i = 1'b0;
    chk("lat_accept_val", 64'(val0), 64'd0);
    chk("lat_accept_rdy", 64'(rdy0), 64'd0);
    tick();
    chk("lat_val",  64'(val0),  64'd1);
    chk("lat_pos",  64'(pos0),  64'd1);
    chk("lat_pos1", 64'(pos1),  64'd1);
    chk("lat_idx",  64'(idx0),  64'd0);
    chk("lat_last", 64'(last0), 64'd1);
    chk("lat_zero", 64'(zero0), 64'd0);
    chk("lat_rdy",  64'(rdy0),  64'd1);
    tick();
    chk("lat_val_drop", 64'(val0), 64'd0);

    // Sparse vector in both orders, all-zero vector, full vector with stalls
    inq.push_back(64'h8000_0000_0000_0101);
    run(0, 100);
    inq.push_back(64'h0);
    run(0, 100);
    inq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    run(1, 400);

    // Back-to-back vectors
    inq.push_back(64'h3);
    inq.push_back(64'h10);
    run(0, 100);

    // Random vectors with random back-pressure
    for (int n = 0; n < 24; n++) begin
      v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) v = '0;
      if ($urandom_range(0, 7) == 0) v = {$urandom, $urandom};
      inq.push_back(v);
    end
    run(2, 6000);

    // Synchronous clear after two outputs; same-cycle val_i is ignored
    rdy_i = 1'b1; val_i = 1'b1; dat_i = 64'hF0F0;
    tick();
    val_i = 1'b0;
    tick();
    chk("clr_pre_pos_a", 64'(pos0), 64'd5);
    tick();
    chk("clr_pre_pos_b", 64'(pos0), 64'd6);
    clr_i = 1'b1; val_i = 1'b1; dat_i = 64'h1;
    tick();
    clr_i = 1'b0; val_i = 1'b0;
    chk("clr_val",  64'(val0),  64'd0);
    chk("clr_rdy",  64'(rdy0),  64'd1);
    chk("clr_last", 64'(last0), 64'd0);
    tick();
    chk("clr_ignored_val", 64'(val0), 64'd0);
    inq.push_back(64'h80);
    run(0, 100);

    // Asynchronous reset in the middle of a scan
    rdy_i = 1'b1; val_i = 1'b1; dat_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    val_i = 1'b0;
    tick();
    tick();
    chk("mid_scan_val", 64'(val0), 64'd1);
    rstn = 1'b0;
    #1 chk_reset_values("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("post_reset_val", 64'(val0), 64'd0);
    inq.push_back(64'h4000);
    run(0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lz77_scan_ones.md
Name: lz77_scan_ones

Overview:
- Iterative, parametrised successor of the LZ77 lowest-set-bit detector.
- Accepts one match-flag vector per transaction.
- Emits the position of every set bit, one per cycle, in LSB-first or MSB-first order, over a valid/ready stream.
- Sits between the LZ77 hash/compare stage (supplies candidate-match vectors) and the match-length evaluator (consumes candidate positions).

Parameters:
- DAT_WD, 64: input vector width; must be a multiple of GRP_WD.
- GRP_WD, 8: group width of the two-level find-first encoder; DAT_WD/GRP_WD groups.
- DIR, 0: scan order. 0 = lowest index first; 1 = highest index first.
- POS_WD, clog2(DAT_WD)+1: position/count width (derived localparam, not user-set).

Ports:
- clk, input, 1: clock.
- rstn, input, 1: asynchronous active-low reset.
- clr_i, input, 1: synchronous abort of the current vector.
- val_i, input, 1: input vector valid.
- dat_i, input, DAT_WD: match-flag vector.
- rdy_o, output, 1: block can accept a vector.
- val_o, output, 1: output position valid.
- pos_o, output, POS_WD: 1-based bit position (index+1); DAT_WD+1 for an all-zero vector.
- idx_o, output, POS_WD: ordinal of this position within the vector, 0-based.
- last_o, output, 1: final output of the vector.
- zero_o, output, 1: vector had no set bit.

Behaviour:
- Clock/reset: single clock clk. Reset rstn is asynchronous, active-low.
- Reset values: state=IDLE, mask=0, ordinal counter=0, rdy_o=1, val_o=0, pos_o=0, idx_o=0, last_o=0, zero_o=0.
- States: IDLE, SCAN.
- IDLE:
  - rdy_o=1.
  - val_i&rdy_o: mask<=dat_i, counter<=0, go SCAN.
- SCAN:
  - rdy_o=0.
  - The output register advances when adv = !val_o | rdy_i.
- On adv in SCAN, with mask!=0:
  - Two-level encoder: group flags = OR of each GRP_WD slice; select first group in DIR order; select first bit within it in DIR order.
  - Load pos_o=index+1, idx_o=counter, zero_o=0, val_o=1.
  - Clear that bit in mask; counter+1.
  - last_o=1 if the remaining mask is 0, then go IDLE; else stay in SCAN.
- On adv in SCAN, with mask==0 (only possible for an all-zero input vector):
  - Load pos_o=DAT_WD+1, idx_o=0, zero_o=1, last_o=1, val_o=1.
  - Go IDLE.
- val_o&rdy_i with no new load: val_o<=0; other output fields hold.
- Holding: while val_o&!rdy_i, all outputs hold stable and mask/counter do not change.
- Latency and throughput:
  - Vector accepted at edge N; first val_o after edge N+1.
  - 1 position per cycle when rdy_i=1.
  - Vector with k set bits: k outputs; rdy_o returns at the edge loading last_o.
  - Next vector can be accepted on the following cycle even while the last output is still held.
- clr_i (priority over everything except rstn): next edge state=IDLE, mask=0, counter=0, val_o=0, last_o=0. val_i in the same cycle is ignored.
- Reset mid-scan: outputs return to reset values immediately; in-flight positions are lost.
- Width rules: pos/idx arithmetic unsigned POS_WD; full vector (all DAT_WD bits set) gives idx_o up to DAT_WD-1 and pos_o up to DAT_WD; no overflow.
- No combinational path from dat_i or rdy_i to val_o, pos_o, idx_o, last_o or zero_o.

Decomposition:
- Shared package lz77_pkg: POS_WD derivation function (LOG2), DIR encodings DIR_LSB=0, DIR_MSB=1, state encodings.
- One sub-module: lz77_find_first.
  - Purely combinational, parametrised DAT_WD/GRP_WD/DIR.
  - Outputs any_o and index (0-based) of the first set bit.
  - Instantiated once on the mask register.

Test Plan:
- DIR=0, dat_i=64'h1, rdy_i=1 -> single output pos_o=1, idx_o=0, last_o=1, zero_o=0; val_o high exactly 1 cycle, 2 cycles after acceptance.
- DIR=0, dat_i=64'h8000_0000_0000_0101 -> pos_o 1,9,64 on consecutive cycles, idx_o 0,1,2, last_o only on 64. DIR=1 same vector -> 64,9,1.
- dat_i=0 -> one output pos_o=65, zero_o=1, last_o=1, idx_o=0; rdy_o high the following cycle.
- dat_i=64'hFFFF_FFFF_FFFF_FFFF with rdy_i toggling 1,0,0,1,... -> 64 outputs pos 1..64 in order, values stable while rdy_i=0, none dropped or duplicated, last_o on pos 64.
- Back-to-back: 64'h3 then 64'h10 -> outputs 1,2(last),5(last); second vector accepted the cycle after first last_o load.
- clr_i asserted after 2 outputs of 64'hF0F0 -> val_o=0 next cycle, rdy_o=1; rstn pulsed mid-scan -> all outputs at reset values asynchronously.
